// File: rtl/core_seq_ctrl.sv
`default_nettype none
// ============================================================================
// core_seq_ctrl : multi-cycle fetch/decode/execute/writeback sequencer
// Rev 1.0
// ============================================================================
module core_seq_ctrl #(
   parameter int                    ADDR_WIDTH     = 32,
   parameter int                    DATA_WIDTH     = 32,
   parameter int                    INST_WIDTH     = 32,
   parameter int                    REG_ADDR_WIDTH = 5,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC       = 32'h8000_0000,
   parameter int                    FETCH_TIMEOUT  = 256
) (
   input  logic                      clk,
   input  logic                      rst,
   output logic                      imem_req_o,
   output logic [ADDR_WIDTH-1:0]     imem_addr_o,
   input  logic                      imem_rvalid_i,
   input  logic [INST_WIDTH-1:0]     imem_rdata_i,
   output logic [INST_WIDTH-1:0]     instr_o,
   output logic [ADDR_WIDTH-1:0]     pc_o,
   input  logic                      invld_instr_i,
   input  logic                      use_rd_i,
   input  logic [REG_ADDR_WIDTH-1:0] rd_i,
   output logic                      exu_start_o,
   input  logic                      exu_done_i,
   input  logic [DATA_WIDTH-1:0]     exu_result_i,
   output logic                      wb_en_o,
   output logic [REG_ADDR_WIDTH-1:0] wb_rd_o,
   output logic [DATA_WIDTH-1:0]     wb_dat_o,
   output logic                      retire_o,
   output logic [31:0]               instret_o,
   output logic                      halt_o,
   output logic [1:0]                halt_cause_o
);

   localparam int                 c_CNT_W    = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'((FETCH_TIMEOUT > 0) ? FETCH_TIMEOUT - 1 : 0);
   localparam logic [1:0]         c_CAUSE_ILLEGAL = 2'd1;
   localparam logic [1:0]         c_CAUSE_TIMEOUT = 2'd2;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_FWAIT  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   state_t                      r_state;
   state_t                      w_state_nxt;
   logic [ADDR_WIDTH-1:0]       r_pc;
   logic [INST_WIDTH-1:0]       r_instr;
   logic [31:0]                 r_instret;
   logic [c_CNT_W-1:0]          r_cnt;
   logic [1:0]                  r_cause;
   logic                        r_exu_start;
   logic                        r_retire;
   logic [REG_ADDR_WIDTH-1:0]   r_rd;
   logic [DATA_WIDTH-1:0]       r_res;

   logic                        w_load_instr;
   logic                        w_done_acc;
   logic                        w_advance;
   logic [1:0]                  w_halt_cause;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_load_instr = 1'b0;
      w_done_acc   = 1'b0;
      w_advance    = 1'b0;
      w_halt_cause = 2'd0;
      case (r_state)
         S_FETCH: w_state_nxt = S_FWAIT;
         S_FWAIT: begin
            // A response in the limit cycle still counts as a good fetch.
            if (imem_rvalid_i) begin
               w_state_nxt  = S_DECODE;
               w_load_instr = 1'b1;
            end else if ((FETCH_TIMEOUT != 0) && (r_cnt == c_CNT_LAST)) begin
               w_state_nxt  = S_HALT;
               w_halt_cause = c_CAUSE_TIMEOUT;
            end
         end
         S_DECODE: begin
            if (invld_instr_i) begin
               w_state_nxt  = S_HALT;
               w_halt_cause = c_CAUSE_ILLEGAL;
            end else begin
               w_state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            if (exu_done_i) begin
               w_done_acc = 1'b1;
               if (use_rd_i && (rd_i != '0)) begin
                  w_state_nxt = S_WB;
               end else begin
                  w_state_nxt = S_FETCH;
                  w_advance   = 1'b1;
               end
            end
         end
         S_WB: begin
            w_state_nxt = S_FETCH;
            w_advance   = 1'b1;
         end
         S_HALT:  w_state_nxt = S_HALT;
         default: w_state_nxt = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc        <= RESET_PC;
         r_instr     <= '0;
         r_instret   <= '0;
         r_cnt       <= '0;
         r_cause     <= 2'd0;
         r_exu_start <= 1'b0;
         r_retire    <= 1'b0;
         r_rd        <= '0;
         r_res       <= '0;
      end else begin
         r_cnt <= (r_state == S_FWAIT) ? r_cnt + c_CNT_W'(1) : '0;
         if (w_load_instr) begin
            r_instr <= imem_rdata_i;
         end
         if (w_done_acc) begin
            r_rd  <= rd_i;
            r_res <= exu_result_i;
         end
         if (w_advance) begin
            r_pc      <= r_pc + ADDR_WIDTH'(4);
            r_instret <= r_instret + 32'd1;
         end
         if (w_halt_cause != 2'd0) begin
            r_cause <= w_halt_cause;
         end
         r_exu_start <= (r_state == S_DECODE) && (w_state_nxt == S_EXEC);
         // Retire is seen the cycle after done: during WB, or in the next FETCH.
         r_retire    <= w_done_acc;
      end
   end

   assign imem_req_o   = (r_state == S_FETCH);
   assign imem_addr_o  = r_pc;
   assign pc_o         = r_pc;
   assign instr_o      = r_instr;
   assign exu_start_o  = r_exu_start;
   assign wb_en_o      = (r_state == S_WB);
   assign wb_rd_o      = wb_en_o ? r_rd  : '0;
   assign wb_dat_o     = wb_en_o ? r_res : '0;
   assign retire_o     = r_retire;
   assign instret_o    = r_instret;
   assign halt_o       = (r_state == S_HALT);
   assign halt_cause_o = r_cause;

endmodule
`default_nettype wire
